// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two valid/ready requesters.
// Define CALC_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties) instead of round-robin.
module alu_arbiter #(
    parameter int NUM_W   = 16,
    parameter int OP_W    = 4,
    parameter int LATENCY = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [NUM_W-1:0] req0_left_i,
    input  logic [NUM_W-1:0] req0_right_i,
    input  logic [OP_W-1:0]  req0_op_i,
    input  logic [NUM_W-1:0] req1_left_i,
    input  logic [NUM_W-1:0] req1_right_i,
    input  logic [OP_W-1:0]  req1_op_i,
    output logic [1:0]       rsp_valid_o,
    output logic [NUM_W-1:0] rsp_result_o,
    output logic [NUM_W-1:0] alu_left_o,
    output logic [NUM_W-1:0] alu_right_o,
    output logic [OP_W-1:0]  alu_op_o,
    input  logic [NUM_W-1:0] alu_result_i,
    output logic             busy_o
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

    if (LATENCY < 1) begin : g_lat_chk
        $error("alu_arbiter: LATENCY must be >= 1");
    end

    typedef struct packed {
        logic [NUM_W-1:0] left;
        logic [NUM_W-1:0] right;
        logic [OP_W-1:0]  op;
    } req_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    req_t [1:0]       req;
    req_t             lat_q;
    logic [NUM_W-1:0] res_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_grant_q;
    logic [1:0]       grant;

    assign req[0] = {req0_left_i, req0_right_i, req0_op_i};
    assign req[1] = {req1_left_i, req1_right_i, req1_op_i};

    // grant is only ever non-zero in IDLE, and is a subset of req_valid_i,
    // so |grant is exactly the transfer condition.
    always_comb begin
        state_d = state_q;
        grant   = 2'b00;
        unique case (state_q)
            IDLE: begin
                unique case (req_valid_i)
                    2'b01:   grant = 2'b01;
                    2'b10:   grant = 2'b10;
`ifdef CALC_ARB_FIXED_PRIO_EN
                    2'b11:   grant = 2'b01;
`else
                    2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
`endif
                    default: grant = 2'b00;
                endcase
                if (|grant) state_d = WAIT;
            end
            WAIT:    if (cnt_q == '0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            lat_q        <= '0;
            res_q        <= '0;
            cnt_q        <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (|grant) begin
                        last_grant_q <= grant[1];
                        lat_q        <= grant[1] ? req[1] : req[0];
                        cnt_q        <= CNT_W'(LATENCY - 1);
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) res_q <= alu_result_i;
                    else             cnt_q <= cnt_q - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Reset gates ready so every output reads 0 while rst_ni is low.
    assign req_ready_o  = rst_ni ? grant : 2'b00;
    assign busy_o       = (state_q != IDLE);
    assign alu_left_o   = busy_o ? lat_q.left  : '0;
    assign alu_right_o  = busy_o ? lat_q.right : '0;
    assign alu_op_o     = busy_o ? lat_q.op    : '0;
    assign rsp_result_o = res_q;

    always_comb begin
        rsp_valid_o = 2'b00;
        if (state_q == RESP) rsp_valid_o[last_grant_q] = 1'b1;
    end

endmodule
